// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, also used by decode and the LSU queue.
package fetch_pkg;

    localparam int INSN_W = 32;
    localparam int PC_W   = 32;

    // Canonical RV32I nop (addi x0,x0,0).
    localparam logic [INSN_W-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: redirect input, imem request/response, decode handshake.
// fetch_misalign exists only when FETCH_MISALIGN_EN is defined.
interface fetch_if #(parameter int ADDR_W = 32);
    import fetch_pkg::*;

    logic              redirect_vld;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req_vld;
    logic              imem_req_rdy;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_vld;
    logic [INSN_W-1:0] imem_rsp_data;
    logic              insn_vld;
    logic              insn_rdy;
    logic [INSN_W-1:0] insn;
    logic [ADDR_W-1:0] insn_pc;
`ifdef FETCH_MISALIGN_EN
    logic              fetch_misalign;
`endif

    modport master (
`ifdef FETCH_MISALIGN_EN
        output fetch_misalign,
`endif
        input  redirect_vld, redirect_pc, imem_req_rdy, imem_rsp_vld, imem_rsp_data, insn_rdy,
        output imem_req_vld, imem_addr, insn_vld, insn, insn_pc
    );

    modport slave (
`ifdef FETCH_MISALIGN_EN
        input  fetch_misalign,
`endif
        output redirect_vld, redirect_pc, imem_req_rdy, imem_rsp_vld, imem_rsp_data, insn_rdy,
        input  imem_req_vld, imem_addr, insn_vld, insn, insn_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and a registered head; generic over entry type.
module fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  entry_t                 din_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   vld_o,
    output entry_t                 dout_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             dout_q, dout_d;
    logic [PTR_W-1:0]   wr_q, rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    // Head register tracks the entry that will be at the front after this cycle;
    // it holds its value when the FIFO drains or is flushed.
    always_comb begin
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (flush_i) begin
            cnt_d = '0;
        end else begin
            rd_d  = rd_q + PTR_W'(do_pop);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
            if ((cnt_q - CNT_W'(do_pop)) != '0)
                dout_d = mem_q[rd_d];
            else if (do_push)
                dout_d = din_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            if (flush_i) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
                wr_q <= wr_q + PTR_W'(do_push);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i)
            mem_q[wr_q] <= din_i;
    end

    assign vld_o   = (cnt_q != '0);
    assign dout_o  = dout_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Stall-tolerant RV32I fetch stage: PC, imem requests, prefetch FIFO, redirect flush.
// Define FETCH_MISALIGN_EN to flag and halt on misaligned redirect targets.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter int                MAX_OUT    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master fe
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = ((FC_W > OUT_W) ? FC_W : OUT_W) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0]  live_q, live_d, stale_q, stale_d;
    logic              run_q;
    logic [FC_W-1:0]   fifo_cnt;
    logic [OUT_W:0]    inflight;
    logic [SUM_W-1:0]  credit;
    logic              halt, req_vld, accept, rsp_live, push, pop, fifo_vld;
    entry_t            push_e, head;

    assign inflight = {1'b0, live_q} + {1'b0, stale_q};
    assign credit   = SUM_W'(fifo_cnt) + SUM_W'(live_q);

    // FIFO slots are reserved at issue, so a live response always has room.
    assign req_vld  = run_q && !halt && !fe.redirect_vld
                   && (inflight < (OUT_W+1)'(MAX_OUT))
                   && (credit < SUM_W'(FIFO_DEPTH));
    assign accept   = req_vld && fe.imem_req_rdy;
    assign rsp_live = fe.imem_rsp_vld && (stale_q == '0);
    assign push     = rsp_live && !fe.redirect_vld;
    assign pop      = fifo_vld && fe.insn_rdy && !fe.redirect_vld;

    // Live requests are consecutive words, so the oldest one sits live_q words behind fetch_pc.
    assign push_e.pc   = fetch_pc_q - (ADDR_W'(live_q) << 2);
    assign push_e.insn = fe.imem_rsp_data;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        live_d     = live_q;
        stale_d    = stale_q;
        if (fe.redirect_vld) begin
            fetch_pc_d = fe.redirect_pc & ~ADDR_W'(3);
            live_d     = '0;
            stale_d    = stale_q + live_q - OUT_W'(fe.imem_rsp_vld);
        end else begin
            if (accept)
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            live_d = live_q + OUT_W'(accept) - OUT_W'(rsp_live);
            if (fe.imem_rsp_vld && (stale_q != '0))
                stale_d = stale_q - OUT_W'(1);
        end
    end

    // run_q holds off the first request until one clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            live_q     <= '0;
            stale_q    <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            live_q     <= live_d;
            stale_q    <= stale_d;
            run_q      <= 1'b1;
        end
    end

`ifdef FETCH_MISALIGN_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            misalign_q <= 1'b0;
        else if (fe.redirect_vld)
            misalign_q <= |fe.redirect_pc[1:0];
    end

    assign fe.fetch_misalign = misalign_q;
    assign halt              = misalign_q;
`else
    assign halt = 1'b0;
`endif

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_e),
        .pop_i   (pop),
        .flush_i (fe.redirect_vld),
        .vld_o   (fifo_vld),
        .dout_o  (head),
        .count_o (fifo_cnt)
    );

    assign fe.imem_req_vld = req_vld;
    assign fe.imem_addr    = fetch_pc_q;
    assign fe.insn_vld     = fifo_vld;
    assign fe.insn         = head.insn;
    assign fe.insn_pc      = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order variable-latency memory model plus decode-side monitor.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(32)) fe();

    fetch_unit #(.ADDR_W(32), .FIFO_DEPTH(4), .MAX_OUT(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .fe  (fe)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;
    int n_acc   = 0;
    int lat     = 1;
    int p0, a0;
    fetch_entry_t exp_q[$];

    typedef struct { logic [31:0] a; int due; } pend_t;
    pend_t pend[$];

    function automatic logic [31:0] mdat(logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // In-order instruction memory, always ready to return, fixed latency 'lat'.
    initial begin : mem_model
        logic        fire;
        logic [31:0] a;
        int          cyc;
        cyc = 0;
        fe.imem_rsp_vld  = 1'b0;
        fe.imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            fire = rst && fe.imem_req_vld && fe.imem_req_rdy;
            a    = fe.imem_addr;
            @(posedge clk); #1;
            cyc++;
            if (!rst) begin
                pend.delete();
                fe.imem_rsp_vld = 1'b0;
            end else begin
                if (fire) begin
                    pend.push_back('{a, cyc - 1 + lat});
                    n_acc++;
                end
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    fe.imem_rsp_vld  = 1'b1;
                    fe.imem_rsp_data = mdat(pend[0].a);
                    void'(pend.pop_front());
                end else begin
                    fe.imem_rsp_vld = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_seq(logic [31:0] base, int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = base + 32'(4 * i);
            exp_q.push_back('{p, mdat(p)});
        end
    endtask

    // Enter reset (held two cycles); caller releases rst.
    task automatic enter_reset(int l);
        rst             = 1'b0;
        fe.redirect_vld = 1'b0;
        fe.redirect_pc  = '0;
        fe.insn_rdy     = 1'b0;
        fe.imem_req_rdy = 1'b1;
        lat             = l;
        exp_q.delete();
        step();
        step();
    endtask

    task automatic monitor();
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (rst && fe.insn_vld && fe.insn_rdy && !fe.redirect_vld) begin
                n_pop++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h insn %h, expected nothing", fe.insn_pc, fe.insn);
                end else begin
                    e = exp_q.pop_front();
                    if (fe.insn_pc !== e.pc || fe.insn !== e.insn) begin
                        n_fail++;
                        $display("FAIL sb_insn: got pc %h insn %h, expected pc %h insn %h",
                                 fe.insn_pc, fe.insn, e.pc, e.insn);
                    end
                end
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        enter_reset(1);
        smp();
        chk("rst_req_vld", 32'(fe.imem_req_vld), 0);
        chk("rst_insn_vld", 32'(fe.insn_vld), 0);
        chk("rst_insn", fe.insn, 0);
        chk("rst_insn_pc", fe.insn_pc, 0);
`ifdef FETCH_MISALIGN_EN
        chk("rst_misalign", 32'(fe.fetch_misalign), 0);
`endif

        // 1: latency 1, streaming
        step();
        fe.insn_rdy = 1'b1;
        push_seq(32'h0, 64);
        p0 = n_pop;
        rst = 1'b1;                                   // C0
        smp(); chk("t1_idle_after_release", 32'(fe.imem_req_vld), 0);
        step(); smp();                                // C1
        chk("t1_first_req", 32'(fe.imem_req_vld), 1);
        chk("t1_first_addr", fe.imem_addr, 32'h0);
        step(); smp();                                // C2
        chk("t1_second_addr", fe.imem_addr, 32'h4);
        for (int k = 0; k < 6; k++) begin             // C3..C8
            step(); smp();
            chk("t1_stream_vld", 32'(fe.insn_vld), 1);
        end
        step();
        chk("t1_pop_count", n_pop - p0, 6);
        fe.insn_rdy = 1'b0;

        // 2: decode stalled, latency 2 -> FIFO fills to 4, then drains in order
        enter_reset(2);
        push_seq(32'h0, 64);
        a0 = n_acc;
        rst = 1'b1;                                   // C0
        repeat (10) step();
        smp();
        chk("t2_hold_pc_early", fe.insn_pc, 32'h0);
        repeat (10) step();                           // C20
        smp();
        chk("t2_req_blocked", 32'(fe.imem_req_vld), 0);
        chk("t2_accepted", n_acc - a0, 4);
        chk("t2_head_vld", 32'(fe.insn_vld), 1);
        chk("t2_head_pc", fe.insn_pc, 32'h0);
        chk("t2_head_insn", fe.insn, mdat(32'h0));
        step();
        p0 = n_pop;
        fe.insn_rdy = 1'b1;
        repeat (10) step();
        chk("t2_drained", 32'(n_pop - p0 >= 6), 1);
        fe.insn_rdy = 1'b0;

        // 3: three requests in flight (latency 3) then redirect to 0x100
        enter_reset(3);
        fe.insn_rdy = 1'b1;
        p0 = n_pop;
        rst = 1'b1;                                   // C0
        repeat (4) step();                            // C4
        fe.redirect_vld = 1'b1;
        fe.redirect_pc  = 32'h100;
        exp_q.delete();
        push_seq(32'h100, 32);
        smp();
        chk("t3_no_req_on_redirect", 32'(fe.imem_req_vld), 0);
        step();                                       // C5
        fe.redirect_vld = 1'b0;
        smp();
        chk("t3_req_vld", 32'(fe.imem_req_vld), 1);
        chk("t3_req_addr", fe.imem_addr, 32'h100);
        chk("t3_stale", 32'(dut.stale_q), 2);
        repeat (12) step();
        chk("t3_new_epoch", 32'(n_pop - p0 >= 3), 1);
        fe.insn_rdy = 1'b0;

        // 4: redirect coinciding with a response and a pop (latency 2)
        enter_reset(2);
        fe.insn_rdy = 1'b1;
        push_seq(32'h0, 64);
        p0 = n_pop;
        rst = 1'b1;                                   // C0
        repeat (6) step();                            // C6
        chk("t4_pre_pops", n_pop - p0, 2);
        fe.redirect_vld = 1'b1;
        fe.redirect_pc  = 32'h200;
        exp_q.delete();
        push_seq(32'h200, 32);
        smp();
        chk("t4_head_vld", 32'(fe.insn_vld), 1);
        step();                                       // C7
        fe.redirect_vld = 1'b0;
        smp();
        chk("t4_flushed", 32'(fe.insn_vld), 0);
        chk("t4_stale", 32'(dut.stale_q), 1);
        chk("t4_live", 32'(dut.live_q), 0);
        chk("t4_req_addr", fe.imem_addr, 32'h200);
        p0 = n_pop;
        repeat (10) step();
        chk("t4_new_epoch", 32'(n_pop - p0 >= 2), 1);
        fe.insn_rdy = 1'b0;

        // 5: PC wrap at top of address space
        enter_reset(1);
        fe.insn_rdy = 1'b1;
        p0 = n_pop;
        rst = 1'b1;                                   // C0
        step();                                       // C1
        fe.redirect_vld = 1'b1;
        fe.redirect_pc  = 32'hFFFF_FFFC;
        push_seq(32'hFFFF_FFFC, 32);
        step();                                       // C2
        fe.redirect_vld = 1'b0;
        smp();
        chk("t5_top_addr", fe.imem_addr, 32'hFFFF_FFFC);
        step(); smp();                                // C3
        chk("t5_wrap_addr", fe.imem_addr, 32'h0);
        repeat (6) step();
        chk("t5_wrap_stream", 32'(n_pop - p0 >= 3), 1);

`ifdef FETCH_MISALIGN_EN
        // 6: misaligned redirect halts fetch until an aligned redirect
        fe.redirect_vld = 1'b1;
        fe.redirect_pc  = 32'h102;
        exp_q.delete();
        step();
        fe.redirect_vld = 1'b0;
        smp();
        chk("t6_flag_set", 32'(fe.fetch_misalign), 1);
        chk("t6_halt", 32'(fe.imem_req_vld), 0);
        repeat (3) step();
        smp();
        chk("t6_still_halted", 32'(fe.imem_req_vld), 0);
        step();
        fe.redirect_vld = 1'b1;
        fe.redirect_pc  = 32'h200;
        exp_q.delete();
        push_seq(32'h200, 32);
        step();
        fe.redirect_vld = 1'b0;
        smp();
        chk("t6_flag_clear", 32'(fe.fetch_misalign), 0);
        chk("t6_resume_vld", 32'(fe.imem_req_vld), 1);
        chk("t6_resume_addr", fe.imem_addr, 32'h200);
        p0 = n_pop;
        repeat (6) step();
        chk("t6_resume_stream", 32'(n_pop - p0 >= 2), 1);
`else
        // 6: misaligned redirect low bits are masked
        fe.redirect_vld = 1'b1;
        fe.redirect_pc  = 32'h106;
        exp_q.delete();
        push_seq(32'h104, 32);
        step();
        fe.redirect_vld = 1'b0;
        smp();
        chk("t6_mask_vld", 32'(fe.imem_req_vld), 1);
        chk("t6_mask_addr", fe.imem_addr, 32'h104);
        p0 = n_pop;
        repeat (6) step();
        chk("t6_mask_stream", 32'(n_pop - p0 >= 2), 1);
`endif
        fe.insn_rdy = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage for the next-generation RV32I core. It replaces the combinational pc/inst_mem pair with a stall-tolerant front end.
- Holds the fetch PC and issues word requests to a variable-latency instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PCs in a prefetch FIFO.
- Supports branch/jump redirect with flush and discard of stale in-flight responses.
- Feeds the decode/control stage through a valid/ready interface.

Parameters:
ADDR_W, 32, width of PC and memory address (bits [1:0] always 0).
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >=2.
MAX_OUT, 4, maximum in-flight memory requests (live plus stale); >=1.
RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
redirect_vld  in  1  taken branch/jump this cycle
redirect_pc  in  ADDR_W  new fetch target
imem_req_vld  out  1  request valid
imem_req_rdy  in  1  memory accepts request
imem_addr  out  ADDR_W  request word address
imem_rsp_vld  in  1  response valid (in order, always accepted)
imem_rsp_data  in  32  returned instruction
insn_vld  out  1  FIFO head valid
insn_rdy  in  1  decode consumes head
insn  out  32  head instruction
insn_pc  out  ADDR_W  head PC
fetch_misalign  out  1  present only with FETCH_MISALIGN_EN

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty.
  - live_out=0, stale_out=0.
  - imem_req_vld=0, insn_vld=0, insn=0, insn_pc=0, fetch_misalign=0.
- imem_addr = fetch_pc.
- imem_req_vld = !redirect_vld && (live_out+stale_out < MAX_OUT) && (fifo_count+live_out < FIFO_DEPTH).
  - The FIFO credit is reserved at issue, so a live response never finds the FIFO full.
  - imem_req_vld never depends on imem_req_rdy.
- Accepted request (vld&&rdy): fetch_pc += 4, wrapping modulo 2^ADDR_W; live_out++.
- Response handling:
  - If stale_out>0: drop the response, stale_out--.
  - Else: push {fetch PC of that request, data}, live_out--.
  - Request PCs are tracked in a small PC queue, or recomputed as head_pc + 4*(count+offset).
- Pop: insn_vld && insn_rdy removes the head.
  - Push and pop in the same cycle keep the count unchanged.
  - insn/insn_pc are stable while insn_vld && !insn_rdy.
- Latency:
  - Response at cycle N → insn_vld at N+1 (registered FIFO, no bypass).
  - Redirect at N → first request to redirect_pc at N+1.
- Redirect (highest priority) in cycle N:
  - FIFO flushed; any pop that cycle is ignored.
  - fetch_pc=redirect_pc & ~3.
  - stale_out = stale_out + live_out - (imem_rsp_vld ? 1 : 0); live_out=0. A response arriving in cycle N is itself dropped.
  - No request is issued in cycle N.
- Redirect while stale_out>0: previous stale responses stay stale; counts accumulate, bounded by MAX_OUT.
- Empty FIFO: insn_vld=0, and insn/insn_pc hold their last value.
- Full FIFO: no new requests.

Optional Feature:
Macro: FETCH_MISALIGN_EN.
- Defined:
  - redirect_pc[1:0]!=0 sets a sticky flag (registered, one cycle after the redirect); fetch_misalign=1.
  - The fetch_misalign port exists.
  - Fetching halts (imem_req_vld=0) until the next aligned redirect clears the flag.
- Undefined:
  - Low bits are silently masked.
  - No port, no flag.

Decomposition:
- Package fetch_pkg holds:
  - fetch_entry_t struct {pc[ADDR_W], insn[32]};
  - INSN_W=32;
  - the NOP constant 32'h0000_0013 used as the reset value of insn in a later decode integration.
- Sub-module fetch_fifo: synchronous FIFO with push/pop/flush/count, parametrised by DEPTH and entry type, reusable by the LSU.

Test Plan:
1. Reset with RESET_PC=0, memory latency 1, always ready, insn_rdy=1 → first request addr 0x0 in the cycle after release; insn_pc sequence 0x0,0x4,0x8 with one insn per cycle in steady state.
2. insn_rdy=0 for 20 cycles, latency 2 → exactly 4 responses buffered, imem_req_vld=0 once count+live_out=4, no data lost; on insn_rdy=1, PCs 0x0..0xC are emitted in order.
3. 3 requests in flight (latency 3), redirect_pc=0x100 → the 3 responses are dropped; first insn_pc=0x100 with the correct data; no old-epoch instruction appears.
4. Redirect in the same cycle as a response and a pop → response dropped, pop ignored, FIFO empty next cycle, stale_out = live_out-1.
5. fetch_pc=0xFFFF_FFFC, ADDR_W=32 → next request addr 0x0000_0000.
6. With FETCH_MISALIGN_EN: redirect_pc=0x102 → fetch_misalign=1 next cycle, imem_req_vld=0; redirect to 0x200 clears the flag and fetching resumes at 0x200.
